// File: rtl/iccm_pkg.sv
// iccm_pkg: shared types and defaults for the ICCM boot loader.
package iccm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} loader_state_e;
  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;
endpackage

// File: rtl/iccm_loader_if.sv
// iccm_loader_if: ICCM wrapper write port driven by the boot loader.
interface iccm_loader_if #(parameter int ADDR_W = 12);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_we;
  modport master (output mem_req, mem_addr, mem_wdata, mem_we);
  modport slave (input mem_req, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/iccm_word_assembler.sv
// iccm_word_assembler: packs a byte stream into little-endian 32-bit words.
module iccm_word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_cnt_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0]  byte_cnt;
  logic [23:0] lo_bytes;
  // Bytes shift in from the top so byte 0 ends up in [7:0]; byte 3 completes the word directly.
  assign word_valid_o = valid_i && byte_cnt == 2'd3;
  assign word_o = {byte_i, lo_bytes};
  assign byte_cnt_o = byte_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      byte_cnt <= 2'd0;
      lo_bytes <= 24'd0;
    end else if (clear_i) begin
      byte_cnt <= 2'd0;
      lo_bytes <= 24'd0;
    end else if (valid_i) begin
      byte_cnt <= byte_cnt + 2'd1;
      lo_bytes <= {byte_i, lo_bytes[23:8]};
    end
endmodule

// File: rtl/iccm_loader.sv
// iccm_loader: boot-time loader writing a UART byte stream into ICCM while holding the core in reset.
module iccm_loader import iccm_pkg::*; #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] END_WORD = END_WORD_DEFAULT,
  parameter logic [15:0] TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          prog_i,
  input  logic [7:0]    rx_byte_i,
  input  logic          rx_valid_i,
  iccm_loader_if.master mem,
  output logic          reset_core_o,
  output logic          done_o,
  output logic          err_o
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  loader_state_e   state;
  logic [ADDR_W:0] word_addr;
  logic [15:0]     idle_cnt;
  logic [15:0]     idle_nxt;
  logic [1:0]      byte_cnt;
  logic [31:0]     word;
  logic            word_valid;
  logic            in_load;
  logic            accept;
  logic            start;
  logic            timeout;
  assign in_load = state == LOAD;
  assign accept = in_load && rx_valid_i;
  assign start = !in_load && prog_i;
  assign idle_nxt = (accept || byte_cnt == 2'd0) ? 16'd0 : idle_cnt == TIMEOUT ? idle_cnt : idle_cnt + 16'd1;
  // Abort on the edge where the idle count reaches the limit with a word half-assembled.
  assign timeout = in_load && byte_cnt != 2'd0 && idle_nxt == TIMEOUT;
  iccm_word_assembler u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start),
    .valid_i     (accept),
    .byte_i      (rx_byte_i),
    .byte_cnt_o  (byte_cnt),
    .word_valid_o(word_valid),
    .word_o      (word)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state         <= IDLE;
      word_addr     <= '0;
      idle_cnt      <= 16'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= 32'd0;
      mem.mem_we    <= 4'h0;
      reset_core_o  <= 1'b1;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      mem.mem_req <= 1'b0;
      mem.mem_we  <= 4'h0;
      idle_cnt    <= idle_nxt;
      if (start) begin
        state         <= LOAD;
        word_addr     <= '0;
        idle_cnt      <= 16'd0;
        mem.mem_addr  <= '0;
        mem.mem_wdata <= 32'd0;
        reset_core_o  <= 1'b1;
        done_o        <= 1'b0;
        err_o         <= 1'b0;
      end else if (in_load && word_valid) begin
        if (word == END_WORD) begin
          state        <= DONE;
          reset_core_o <= 1'b0;
          done_o       <= 1'b1;
        end else if (word_addr == DEPTH) begin
          state <= ERROR;
          err_o <= 1'b1;
        end else begin
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= 4'hF;
          mem.mem_addr  <= word_addr[ADDR_W-1:0];
          mem.mem_wdata <= word;
          word_addr     <= word_addr + (ADDR_W+1)'(1);
        end
      end else if (timeout) begin
        state <= ERROR;
        err_o <= 1'b1;
      end
    end
endmodule

// File: tb/tb_iccm_loader.sv
// tb_iccm_loader: randomized self-checking bench for iccm_loader against a word-level stream model.
module tb_iccm_loader;
  typedef struct packed { logic [11:0] a; logic [31:0] d; logic [31:0] c; } wr_t;
  localparam logic [31:0] END_W = 32'h0000_0FFF;
  logic clk_i = 1'b0, rst_ni = 1'b1, prog_i = 1'b0, rx_valid_i = 1'b0;
  logic [7:0] rx_byte_i = 8'h00;
  logic rc[3], dn[3], er[3], req[3];
  logic [3:0] we[3];
  logic [11:0] addr[3];
  logic [31:0] wdata[3];
  int checks = 0, errors = 0, cyc = 0, sel = 0, bad = 0;
  wr_t act[$], exp_q[$];
  logic [7:0] tx[$];
  bit exp_done, exp_err;
  iccm_loader_if #(.ADDR_W(12)) m0 ();
  iccm_loader_if #(.ADDR_W(2)) m1 ();
  iccm_loader_if #(.ADDR_W(12)) m2 ();
  iccm_loader #(.ADDR_W(12)) u0 (.clk_i(clk_i), .rst_ni(rst_ni), .prog_i(prog_i), .rx_byte_i(rx_byte_i),
    .rx_valid_i(rx_valid_i), .mem(m0), .reset_core_o(rc[0]), .done_o(dn[0]), .err_o(er[0]));
  iccm_loader #(.ADDR_W(2)) u1 (.clk_i(clk_i), .rst_ni(rst_ni), .prog_i(prog_i), .rx_byte_i(rx_byte_i),
    .rx_valid_i(rx_valid_i), .mem(m1), .reset_core_o(rc[1]), .done_o(dn[1]), .err_o(er[1]));
  iccm_loader #(.ADDR_W(12), .TIMEOUT(16'd10)) u2 (.clk_i(clk_i), .rst_ni(rst_ni), .prog_i(prog_i),
    .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i), .mem(m2), .reset_core_o(rc[2]), .done_o(dn[2]), .err_o(er[2]));
  assign req[0] = m0.mem_req;
  assign req[1] = m1.mem_req;
  assign req[2] = m2.mem_req;
  assign we[0] = m0.mem_we;
  assign we[1] = m1.mem_we;
  assign we[2] = m2.mem_we;
  assign addr[0] = m0.mem_addr;
  assign addr[1] = {10'd0, m1.mem_addr};
  assign addr[2] = m2.mem_addr;
  assign wdata[0] = m0.mem_wdata;
  assign wdata[1] = m1.mem_wdata;
  assign wdata[2] = m2.mem_wdata;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) begin
    if (req[sel]) act.push_back(wr_t'({addr[sel], wdata[sel], 32'(cyc)}));
    if (we[sel] !== (req[sel] ? 4'hF : 4'h0)) bad++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_byte_i = b;
    rx_valid_i = 1'b1;
    tick(1);
    rx_valid_i = 1'b0;
  endtask
  task automatic start_load();
    prog_i = 1'b1;
    tick(1);
    prog_i = 1'b0;
  endtask
  task automatic fresh();
    rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    tick(1);
    start_load();
  endtask
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) tx.push_back(w[8*k +: 8]);
  endtask
  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    do w = $urandom; while (w == END_W);
    return w;
  endfunction
  // Model: every 4th byte completes a word; marker ends the load, word index >= depth aborts it,
  // anything else is written at the next index in the cycle right after its last byte.
  task automatic run_stream(input int maxgap, input int depth);
    logic [31:0] w = 32'd0;
    int n = 0;
    bit stopped = 1'b0;
    exp_q.delete();
    act.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    foreach (tx[i]) begin
      if (i > 0 && maxgap > 0) tick($urandom_range(maxgap));
      w[8*(i%4) +: 8] = tx[i];
      send_byte(tx[i]);
      if (i % 4 == 3 && !stopped) begin
        if (w == END_W) begin
          exp_done = 1'b1;
          stopped = 1'b1;
        end else if (n >= depth) begin
          exp_err = 1'b1;
          stopped = 1'b1;
        end else begin
          exp_q.push_back(wr_t'({12'(n), w, 32'(cyc)}));
          n++;
        end
      end
    end
    tx.delete();
  endtask
  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({req[d], we[d], addr[d], wdata[d]} !== 49'd0) begin
        errors++;
        $display("FAIL reset_mem%0d: got req=%b we=%h a=%h d=%h, want all zero", d, req[d], we[d], addr[d], wdata[d]);
      end
      checks++;
      if ({rc[d], dn[d], er[d]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_flags%0d: got rc/dn/er=%b%b%b, want 100", d, rc[d], dn[d], er[d]);
      end
    end
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    sel = 0;
    act.delete();
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    tick(2);
    checks++;
    if (act.size() != 0 || {rc[0], dn[0], er[0]} !== 3'b100) begin
      errors++;
      $display("FAIL idle_drop: got %0d writes rc/dn/er=%b%b%b, want 0 writes 100", act.size(), rc[0], dn[0], er[0]);
    end
  endtask
  task automatic test_basic();
    sel = 0;
    start_load();
    tx = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00};
    run_stream(3, 4096);
    tick(2);
    checks++;
    if (act.size() != 3 || act[0].d !== 32'h12345678 || act[1].d !== 32'hDEADBEEF || act[2].d !== 32'h1) begin
      errors++;
      $display("FAIL basic_data: got %0d writes d0=%h d1=%h d2=%h, want 3 writes 12345678 deadbeef 00000001",
        act.size(), act[0].d, act[1].d, act[2].d);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= act.size() || act[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_wr%0d: got a=%0d d=%h c=%0d, want a=%0d d=%h c=%0d", i, act[i].a, act[i].d, act[i].c,
          exp_q[i].a, exp_q[i].d, exp_q[i].c);
      end
    end
    checks++;
    if ({dn[0], rc[0], er[0]} !== {exp_done, 1'b0, exp_err}) begin
      errors++;
      $display("FAIL basic_done: got dn/rc/er=%b%b%b, want 100", dn[0], rc[0], er[0]);
    end
  endtask
  task automatic test_restart();
    logic [31:0] w = rnd_word();
    sel = 0;
    start_load();
    checks++;
    if ({rc[0], dn[0], er[0]} !== 3'b100) begin
      errors++;
      $display("FAIL restart_clear: got rc/dn/er=%b%b%b, want 100", rc[0], dn[0], er[0]);
    end
    push_word(w);
    run_stream(2, 4096);
    tick(2);
    checks++;
    if (act.size() != 1 || act[0].a !== 12'd0 || act[0].d !== w || rc[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_write: got n=%0d a=%0d d=%h rc=%b, want n=1 a=0 d=%h rc=1", act.size(), act[0].a, act[0].d, rc[0], w);
    end
    push_word(END_W);
    run_stream(2, 4096);
    tick(2);
    checks++;
    if (act.size() != 0 || {dn[0], rc[0]} !== 2'b10) begin
      errors++;
      $display("FAIL restart_end: got n=%0d dn/rc=%b%b, want n=0 dn/rc=10", act.size(), dn[0], rc[0]);
    end
  endtask
  task automatic test_back_to_back();
    sel = 0;
    start_load();
    for (int k = 0; k < 6; k++) push_word(rnd_word());
    push_word(END_W);
    run_stream(0, 4096);
    tick(2);
    checks++;
    if (act.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, want %0d", act.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= act.size() || act[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_wr%0d: got a=%0d d=%h c=%0d, want a=%0d d=%h c=%0d", i, act[i].a, act[i].d, act[i].c,
          exp_q[i].a, exp_q[i].d, exp_q[i].c);
      end
    end
    checks++;
    if (act.size() < 2 || act[1].c - act[0].c != 32'd4) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between writes, want 4", act[1].c - act[0].c);
    end
    checks++;
    if ({dn[0], rc[0]} !== {exp_done, 1'b0}) begin
      errors++;
      $display("FAIL b2b_done: got dn/rc=%b%b, want 10", dn[0], rc[0]);
    end
  endtask
  task automatic test_overflow();
    sel = 1;
    fresh();
    for (int k = 0; k < 6; k++) push_word(rnd_word());
    run_stream(3, 4);
    tick(2);
    checks++;
    if (act.size() != 4 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL ovf_count: got %0d writes, want 4", act.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= act.size() || act[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_wr%0d: got a=%0d d=%h c=%0d, want a=%0d d=%h c=%0d", i, act[i].a, act[i].d, act[i].c,
          exp_q[i].a, exp_q[i].d, exp_q[i].c);
      end
    end
    checks++;
    if ({er[1], rc[1], dn[1]} !== {exp_err, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_flags: got er/rc/dn=%b%b%b, want 110", er[1], rc[1], dn[1]);
    end
    start_load();
    checks++;
    if ({er[1], rc[1]} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_restart: got er/rc=%b%b, want 01", er[1], rc[1]);
    end
  endtask
  task automatic test_timeout();
    sel = 2;
    fresh();
    act.delete();
    send_byte(8'($urandom));
    tick(9);
    send_byte(8'($urandom));
    checks++;
    if (er[2] !== 1'b0) begin
      errors++;
      $display("FAIL tmo_gap9: got er=%b, want 0", er[2]);
    end
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      checks++;
      if (er[2] !== 1'(k == 10)) begin
        errors++;
        $display("FAIL tmo_cycle%0d: got er=%b, want %b", k, er[2], k == 10);
      end
    end
    checks++;
    if (act.size() != 0 || rc[2] !== 1'b1) begin
      errors++;
      $display("FAIL tmo_nowrite: got %0d writes rc=%b, want 0 writes rc=1", act.size(), rc[2]);
    end
  endtask
  task automatic test_reset_mid_word();
    logic [31:0] w1 = rnd_word() | 32'h100;
    logic [31:0] w2 = rnd_word();
    sel = 0;
    fresh();
    push_word(w1);
    run_stream(1, 4096);
    tick(2);
    send_byte(8'hA5);
    send_byte(8'h5A);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({req[0], we[0], addr[0], wdata[0], rc[0], dn[0], er[0]} !== {49'd0, 3'b100}) begin
      errors++;
      $display("FAIL midrst_outputs: got req=%b we=%h a=%h d=%h rc/dn/er=%b%b%b, want zeros and 100",
        req[0], we[0], addr[0], wdata[0], rc[0], dn[0], er[0]);
    end
    #1 rst_ni = 1'b1;
    tick(1);
    start_load();
    push_word(w2);
    push_word(END_W);
    run_stream(2, 4096);
    tick(2);
    checks++;
    if (act.size() != 1 || act[0].a !== 12'd0 || act[0].d !== w2 || act[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL midrst_reload: got n=%0d a=%0d d=%h c=%0d, want n=1 a=0 d=%h c=%0d", act.size(), act[0].a,
        act[0].d, act[0].c, w2, exp_q[0].c);
    end
    checks++;
    if ({dn[0], rc[0]} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_done: got dn/rc=%b%b, want 10", dn[0], rc[0]);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_mid_word();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL we_protocol: got %0d cycles with mem_we inconsistent with mem_req, want 0", bad);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
